// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and small index helpers for the sprite layer loader.
package sprite_pkg;

   localparam int unsigned SPRITE_DIM = 16;
   localparam int unsigned PIX_W      = 8;
   localparam int unsigned ID_W       = 5;
   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned DATA_W     = 24;
   localparam int unsigned N_LAYERS   = 4;
   localparam int unsigned LG_W       = $clog2(N_LAYERS);

   // Index of the final pixel of a sprite (16x16 -> 255)
   localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(SPRITE_DIM * SPRITE_DIM - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [LG_W-1:0] onehot_to_idx(input logic [N_LAYERS-1:0] oh);
      logic [LG_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N_LAYERS; i++) begin
         if (oh[i]) idx = LG_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [N_LAYERS-1:0] idx_to_onehot(input logic [LG_W-1:0] idx);
      logic [N_LAYERS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   function automatic logic [ID_W-1:0] sprite_id_of(input logic [N_LAYERS*ID_W-1:0] ids,
                                                    input logic [LG_W-1:0]          layer);
      return ids[layer*ID_W +: ID_W];
   endfunction

endpackage

// File: rtl/sprite_layer_loader_if.sv
// Request, sprite-memory and layer-buffer signals of the sprite layer loader.
interface sprite_layer_loader_if;
   import sprite_pkg::*;

   logic [N_LAYERS-1:0]      req;
   logic [N_LAYERS*ID_W-1:0] req_sprite_id;
   logic [N_LAYERS-1:0]      ack;
   logic                     busy;
   logic                     mem_rden;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_rdata;
   logic                     lay_wren;
   logic [LG_W-1:0]          lay_sel;
   logic [PIX_W-1:0]         lay_addr;
   logic [DATA_W-1:0]        lay_wdata;

   // Loader side
   modport master (
      input  req, req_sprite_id, mem_rdata,
      output ack, busy, mem_rden, mem_addr, lay_wren, lay_sel, lay_addr, lay_wdata
   );

   // Requesters, sprite memory and layer buffers
   modport slave (
      output req, req_sprite_id, mem_rdata,
      input  ack, busy, mem_rden, mem_addr, lay_wren, lay_sel, lay_addr, lay_wdata
   );

endinterface

// File: rtl/sprite_layer_loader_arb.sv
// Four-way round-robin arbiter: the search begins one past the previous winner.
module rr_arbiter4
   import sprite_pkg::*;
(
   input  logic [N_LAYERS-1:0] req,
   input  logic [LG_W-1:0]     last_grant,
   output logic [N_LAYERS-1:0] grant,
   output logic                valid
);

   logic [LG_W-1:0] idx;

   // Rotating priority search; the first requester after last_grant wins
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= N_LAYERS; i++) begin
         idx = LG_W'(last_grant + i);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_layer_loader.sv
// Copies a 16x16 sprite from sprite memory into the buffer of one requesting layer.
// Reads stream out in FETCH; each read's data is written one cycle later.
module sprite_layer_loader #(
   parameter int N_LAYERS = 4,
   parameter int DATA_W   = 24
) (
   input logic                   clock,
   input logic                   reset,
   sprite_layer_loader_if.master bus
);
   import sprite_pkg::*;

   state_t              state;
   state_t              state_n;
   logic [PIX_W-1:0]    pix;
   logic [PIX_W-1:0]    wr_pix;
   logic [ID_W-1:0]     id_q;
   logic [LG_W-1:0]     layer_q;
   logic [LG_W-1:0]     last_grant;
   logic                wr_valid;
   logic                grant_load;
   logic                rden;
   logic                done;
   logic [N_LAYERS-1:0] arb_grant;
   logic                arb_valid;
   logic [LG_W-1:0]     grant_idx;
   logic [DATA_W-1:0]   wdata;

   rr_arbiter4 u_arb (
      .req        (bus.req),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .valid      (arb_valid)
   );

   assign grant_idx = onehot_to_idx(arb_grant);

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   // Next-state and per-state strobes; requests are only looked at in IDLE
   always_comb begin
      state_n    = state;
      grant_load = 1'b0;
      rden       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arb_valid) begin
               grant_load = 1'b1;
               state_n    = ST_FETCH;
            end
         end
         ST_FETCH: begin
            rden = 1'b1;
            if (pix == LAST_PIX) state_n = ST_DRAIN;
         end
         ST_DRAIN: state_n = ST_DONE;
         ST_DONE: begin
            done    = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Grant latch, pixel counter and the one-cycle-delayed write pipeline
   always_ff @(posedge clock) begin
      if (!reset) begin
         pix        <= '0;
         wr_pix     <= '0;
         id_q       <= '0;
         layer_q    <= '0;
         last_grant <= LG_W'(N_LAYERS - 1);
         wr_valid   <= 1'b0;
      end else begin
         wr_valid <= rden;
         wr_pix   <= pix;
         if (grant_load) begin
            id_q       <= sprite_id_of(bus.req_sprite_id, grant_idx);
            layer_q    <= grant_idx;
            last_grant <= grant_idx;
            pix        <= '0;
         end else if (rden) begin
            pix <= pix + 1'b1;
         end
      end
   end

   // {id, pix} is id*256 + pix and spans 0..8191 exactly
   assign bus.mem_rden  = rden;
   assign bus.mem_addr  = rden ? {id_q, pix} : '0;
   assign wdata         = wr_valid ? bus.mem_rdata : '0;
   assign bus.lay_wren  = wr_valid;
   assign bus.lay_sel   = wr_valid ? layer_q : '0;
   assign bus.lay_addr  = wr_valid ? wr_pix : '0;
   assign bus.lay_wdata = wdata;
   assign bus.ack       = done ? idx_to_onehot(layer_q) : '0;
   assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_sprite_layer_loader.sv
// Randomized bench for sprite_layer_loader against a timeline model of one load.
module tb_sprite_layer_loader;

   logic clock = 1'b0;
   logic reset = 1'b0;

   sprite_layer_loader_if bus();

   sprite_layer_loader #(.N_LAYERS(4), .DATA_W(24)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [23:0] mem [0:8191];
   int n_checks   = 0;
   int n_pass     = 0;
   int model_last = 3;

   // Sprite memory: data one cycle after the strobe, garbage otherwise
   always @(posedge clock) begin
      if (bus.mem_rden) bus.mem_rdata <= mem[bus.mem_addr];
      else              bus.mem_rdata <= 24'($urandom);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // {rden, mem_addr, wren, lay_sel, lay_addr, lay_wdata, ack, busy}
   function automatic logic [63:0] obs();
      return {10'd0, bus.mem_rden, bus.mem_addr, bus.lay_wren, bus.lay_sel,
              bus.lay_addr, bus.lay_wdata, bus.ack, bus.busy};
   endfunction

   // Expected outputs c cycles after the grant cycle of a load of sprite id into layer l
   function automatic logic [63:0] expect_vec(input int c, input int id, input int l);
      logic        rd, wr, bz;
      logic [12:0] ra;
      logic [1:0]  sel;
      logic [7:0]  la;
      logic [23:0] wd;
      logic [3:0]  ak;
      rd = (c >= 1 && c <= 256);
      wr = (c >= 2 && c <= 257);
      ra = '0; sel = '0; la = '0; wd = '0; ak = '0;
      if (rd) ra = 13'(id * 256 + c - 1);
      if (wr) begin
         sel = 2'(l);
         la  = 8'(c - 2);
         wd  = mem[id * 256 + c - 2];
      end
      if (c == 258) ak = 4'(1 << l);
      bz = (c >= 1 && c <= 258);
      return {10'd0, rd, ra, wr, sel, la, wd, ak, bz};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check("idle", obs(), 64'd0);
      end
   endtask

   // Called in an IDLE cycle with req already applied; returns in the following IDLE cycle
   task automatic run_load(input int chg_at, input int abort_at, input bit drop);
      int l;
      int id;
      l = -1;
      if (bus.req == 4'd0) bus.req = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         int cand;
         cand = (model_last + k) % 4;
         if (l < 0 && bus.req[cand]) l = cand;
      end
      id = int'(bus.req_sprite_id[l*5 +: 5]);
      model_last = l;
      check("grant_cycle", obs(), 64'd0);
      for (int c = 1; c <= 258; c++) begin
         tick();
         check($sformatf("load L%0d id%0d c%0d", l, id, c), obs(), expect_vec(c, id, l));
         if (c == chg_at) begin
            bus.req_sprite_id = 20'($urandom);
            bus.req           = 4'($urandom);
         end
         if (c == abort_at) begin
            reset = 1'b0;
            tick();
            check("after_reset", obs(), 64'd0);
            reset      = 1'b1;
            model_last = 3;
            return;
         end
      end
      tick();
      check("post_ack", obs(), 64'd0);
      if (drop) bus.req[l] = 1'b0;
   endtask

   initial begin
      bus.req           = '0;
      bus.req_sprite_id = '0;
      for (int a = 0; a < 8192; a++) mem[a] = 24'(a);

      // Reset state
      tick();
      tick();
      check("reset", obs(), 64'd0);
      reset = 1'b1;
      idle_cycles(3);

      // Layer 0, sprite 3, memory data equals address
      bus.req           = 4'b0001;
      bus.req_sprite_id = 20'd3;
      run_load(0, 0, 1'b1);
      idle_cycles(2);

      for (int a = 0; a < 8192; a++) mem[a] = 24'($urandom);

      // All layers held requesting from reset: layers 0,1,2,3 in turn
      reset = 1'b0;
      tick();
      reset      = 1'b1;
      model_last = 3;
      bus.req           = 4'b1111;
      bus.req_sprite_id = 20'($urandom);
      for (int i = 0; i < 4; i++) run_load(0, 0, 1'b0);
      bus.req = '0;
      idle_cycles(2);

      // Highest sprite id on layer 2
      bus.req           = 4'b0100;
      bus.req_sprite_id = 20'($urandom);
      bus.req_sprite_id[14:10] = 5'd31;
      run_load(0, 0, 1'b1);

      // Sprite ids and requests scrambled mid-load
      bus.req           = 4'($urandom_range(1, 15));
      bus.req_sprite_id = 20'($urandom);
      run_load(100, 0, 1'b1);

      // Randomized loads
      for (int i = 0; i < 6; i++) begin
         bus.req           = 4'($urandom_range(1, 15));
         bus.req_sprite_id = 20'($urandom);
         run_load(int'($urandom_range(1, 258)), 0, 1'($urandom));
      end

      // Reset in the middle of a load, then layer 0 wins again
      bus.req           = 4'($urandom_range(1, 15));
      bus.req_sprite_id = 20'($urandom);
      run_load(0, 50, 1'b1);
      bus.req = '0;
      idle_cycles(3);
      bus.req           = 4'b1111;
      bus.req_sprite_id = 20'($urandom);
      run_load(0, 0, 1'b1);
      bus.req = '0;
      idle_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
